// File: rtl/uart_mem_bridge_pkg.sv
// uart_mem_bridge shared definitions.
// Opcodes, response bytes, FSM state encoding and reset level.
package uart_mem_bridge_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_NAK = 8'h3F;

    localparam logic RstEnable = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_ADDR   = 3'd1,
        ST_RX_DATA   = 3'd2,
        ST_MEM       = 3'd3,
        ST_SEND_RESP = 3'd4,
        ST_SEND_NAK  = 3'd5
    } state_t;

    function automatic logic is_rx_state(state_t s);
        return (s == ST_RX_ADDR) || (s == ST_RX_DATA);
    endfunction

endpackage

// File: rtl/uart_mem_bridge_timer.sv
// Inter-byte timeout counter for the bridge packet parser.
// Counts idle cycles while enabled; expire flags the last allowed cycle.
module uart_bridge_timer
    import uart_mem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count idle cycles; held at zero outside the receive states
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || !en) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_mem_bridge.sv
// Serial command engine: parses read/write packets from the receive queue,
// performs one 32-bit memory access, and queues the response bytes.
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_avail,
    input  logic [7:0]       rx_data,
    output logic             rx_pop,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_push,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic [ERR_W-1:0] err_count
);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             is_wr_q, is_wr_d;
    logic             pop_gap_q, pop_gap_d;
    logic             push_gap_q, push_gap_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rbuf_q, rbuf_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W-1:0] err_inc;
    logic             expire;
    logic             pop_c;
    logic             push_c;
    logic [7:0]       tx_data_c;

    uart_bridge_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (pop_c),
        .en    (is_rx_state(state_q)),
        .expire(expire)
    );

    // Queue handshakes: never in back-to-back cycles, never on expiry
    always_comb begin
        pop_c = (rst != RstEnable) && rx_avail && !pop_gap_q &&
                ((state_q == ST_IDLE) ||
                 (is_rx_state(state_q) && !expire));
        push_c = (rst != RstEnable) && tx_ready && !push_gap_q &&
                 ((state_q == ST_SEND_RESP) || (state_q == ST_SEND_NAK));
        tx_data_c = 8'h00;
        if (state_q == ST_SEND_NAK) begin
            tx_data_c = RSP_NAK;
        end else if (state_q == ST_SEND_RESP) begin
            tx_data_c = is_wr_q ? RSP_ACK : rbuf_q[8*idx_q +: 8];
        end
    end

    // Packet parser, memory access and response sequencing
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        is_wr_d    = is_wr_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        err_inc    = (err_q == '1) ? err_q : err_q + ERR_W'(1);
        err_d      = err_q;
        pop_gap_d  = pop_c;
        push_gap_d = push_c;
        unique case (state_q)
            ST_IDLE: begin
                if (pop_c) begin
                    if ((rx_data == OP_WR) || (rx_data == OP_RD)) begin
                        is_wr_d = (rx_data == OP_WR);
                        idx_d   = 2'd0;
                        state_d = ST_RX_ADDR;
                    end else begin
                        state_d = ST_SEND_NAK;
                    end
                end
            end
            ST_RX_ADDR: begin
                if (expire) begin
                    err_d   = err_inc;
                    state_d = ST_IDLE;
                end else if (pop_c) begin
                    addr_d[8*idx_q +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = ST_RX_DATA;
                        end else begin
                            state_d   = ST_MEM;
                            mem_req_d = 1'b1;
                            mem_we_d  = 1'b0;
                        end
                    end
                end
            end
            ST_RX_DATA: begin
                if (expire) begin
                    err_d   = err_inc;
                    state_d = ST_IDLE;
                end else if (pop_c) begin
                    wdata_d[8*idx_q +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d   = ST_MEM;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    rbuf_d    = mem_rdata;
                    idx_d     = 2'd0;
                    state_d   = ST_SEND_RESP;
                end
            end
            ST_SEND_RESP: begin
                if (push_c) begin
                    idx_d = idx_q + 2'd1;
                    if (is_wr_q || (idx_q == 2'd3)) begin
                        idx_d   = 2'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SEND_NAK: begin
                if (push_c) begin
                    err_d   = err_inc;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            is_wr_q    <= 1'b0;
            pop_gap_q  <= 1'b0;
            push_gap_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rbuf_q     <= 32'h0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            is_wr_q    <= is_wr_d;
            pop_gap_q  <= pop_gap_d;
            push_gap_q <= push_gap_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            err_q      <= err_d;
        end
    end

    assign rx_pop    = pop_c;
    assign tx_push   = push_c;
    assign tx_data   = tx_data_c;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_count = err_q;

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
Host-side command engine that sits on the CPU/byte side of uart_comm. It pops received bytes, parses fixed-format read/write packets, and performs single 32-bit memory accesses over a req/ack bus. It then pushes response bytes back into uart_comm's send queue. It is the consumer of the receive queue and the producer for the send queue, which lets a PC load and inspect memory over the serial link.

Parameters:
TIMEOUT_CYCLES, 2000000, max idle cycles between bytes inside a packet before abort (about 20 ms at 100 MHz).
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rx_avail  in  1  receive queue non-empty (uart_comm receivable)
rx_data  in  8  head byte of the receive queue; valid while rx_avail=1
rx_pop  out  1  one-cycle pulse; consumes the head byte, which is sampled in the same cycle
tx_ready  in  1  send queue not full (uart_comm sendable)
tx_data  out  8  byte to send; valid with tx_push
tx_push  out  1  one-cycle pulse; writes tx_data into the send queue
mem_req  out  1  memory request; held high until mem_ack
mem_we  out  1  1=write, 0=read; stable while mem_req
mem_addr  out  32  word address; stable while mem_req
mem_wdata  out  32  write data; stable while mem_req
mem_rdata  in  32  read data; valid in the mem_ack cycle
mem_ack  in  1  one-cycle completion pulse
busy  out  1  high in any state other than IDLE
err_count  out  ERR_W  saturating count of NAKs and timeouts

Behaviour:
- Packet format, multi-byte fields little-endian:
  - Write: OP_WR, A0..A3, D0..D3.
  - Read: OP_RD, A0..A3.
- Responses:
  - Write completes: one byte ACK.
  - Read completes: R0..R3 of mem_rdata, little-endian.
  - Unknown opcode: one byte NAK.
- Reset: all outputs 0 (rx_pop, tx_push, mem_req, mem_we, mem_addr, mem_wdata, tx_data, busy, err_count); state IDLE; byte index 0; timer 0.
- Reset mid-operation: mem_req drops in the next cycle, the partial packet is discarded, and nothing is sent.
- Pop rule: pop only when rx_avail=1. After any pop, the next cycle never pops, because queue flags update one cycle late. The same gap rule applies to tx_push against tx_ready.
- States:
  - IDLE: on rx_avail, pop the opcode.
    - OP_WR or OP_RD -> RX_ADDR, with index=0.
    - Any other opcode -> SEND_NAK.
  - RX_ADDR: pop 4 bytes into mem_addr[8i+7:8i]. After byte 3: OP_WR -> RX_DATA; OP_RD -> MEM.
  - RX_DATA: pop 4 bytes into mem_wdata. After byte 3 -> MEM.
  - MEM: mem_req=1 starting the first cycle in this state, which is the cycle after the last byte pop. On mem_ack: mem_req=0 in the next cycle, read data is latched into a 32-bit buffer, then -> SEND_RESP. There is no timeout in MEM.
  - SEND_RESP: write pushes ACK once. Read pushes 4 bytes, low byte first, each only when tx_ready=1 and respecting the gap rule. After the final push -> IDLE.
  - SEND_NAK: push NAK when tx_ready, increment err_count, -> IDLE.
- Inter-byte timer (RX_ADDR and RX_DATA only):
  - Clears on every pop and on entering either state; otherwise increments.
  - At TIMEOUT_CYCLES-1 it aborts: -> IDLE, err_count+1, no response, and partial bytes are discarded.
  - A byte arriving in the same cycle as expiry is not popped; it is later taken as a new opcode.
- err_count saturates at all-ones. NAK and timeout in the same cycle is impossible, since they occur in disjoint states.
- A byte popped in the cycle mem_ack arrives is impossible, since MEM never pops. Bytes queued during MEM or SEND stay in the receive queue.
- Minimum read turnaround: mem_ack at cycle t gives the first tx_push at t+1 if tx_ready.

Decomposition:
- Shared defines header: OP_WR=8'h57 ('W'), OP_RD=8'h52 ('R'), RSP_ACK=8'h4B ('K'), RSP_NAK=8'h3F ('?'), state encodings, RstEnable.
- One natural sub-module: uart_bridge_timer, the inter-byte timeout counter with clear, enable and expire pulse.

Test Plan:
- Write 57 10 00 00 00 EF BE AD DE, mem_ack 3 cycles after req -> mem_we=1, mem_addr=0x00000010, mem_wdata=0xDEADBEEF, single push 4B, busy low after push.
- Read 52 10 00 00 00, mem_rdata=0x11223344 at ack -> pushes 44 33 22 11 in order, with no two pushes in adjacent cycles.
- Opcode 0x00 -> single push 3F, err_count 0->1, next byte parsed as a new opcode.
- Read with tx_ready low for 50 cycles after ack -> no push while low, then all 4 bytes, with data unchanged.
- Send 57 10 00, then stall beyond TIMEOUT_CYCLES (bench sets it to 100) -> IDLE, err_count+1, no push, no mem_req. A following valid read completes normally.
- Assert rst while mem_req=1 -> mem_req=0 the cycle after, all outputs at reset values, no response byte.
